// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer: FSM encoding, default timing, stage indices.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    DELAY    = 2'd0,
    WAIT_RDY = 2'd1,
    DONE     = 2'd2
  } seq_state_e;

  localparam int unsigned DEF_STAGE_DELAY    = 1200;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 120000;

  localparam int unsigned STG_ADC = 0;
  localparam int unsigned STG_BUF = 1;
  localparam int unsigned STG_VGA = 2;

  // Bits needed for a counter that runs 0 .. span-1, span being the longest interval it must time.
  function automatic int unsigned cnt_width(input int unsigned delay,
                                            input int unsigned timeout,
                                            input bit          timeout_en);
    int unsigned span;
    span = (timeout_en && timeout > delay) ? timeout : delay;
    return (span <= 1) ? 1 : $clog2(span);
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchroniser bank for asynchronous level inputs; clears to 0 on async active-low reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-domain resets in order with a programmable delay and a ready handshake per stage.
// Optional ready timeout with sticky flag is enabled by defining RESET_SEQ_TIMEOUT_EN.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned N_STAGES       = 3,
  parameter int unsigned STAGE_DELAY    = DEF_STAGE_DELAY,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = 17
) (
  input  logic                clk_i,
  input  logic                resetn_i,
  input  logic [N_STAGES-1:0] stage_ready_i,
  output logic [N_STAGES-1:0] stage_rstn_o,
  output logic [2:0]          stage_idx_o,
  output logic                seq_done_o,
  output logic                seq_timeout_o
);

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam int unsigned CW = CNT_W;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
`else
  localparam int unsigned CW_MIN = cnt_width(STAGE_DELAY, TIMEOUT_CYCLES, 1'b0);
  localparam int unsigned CW     = (CW_MIN < CNT_W) ? CW_MIN : CNT_W;
`endif
  localparam logic [CW-1:0] DELAY_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(N_STAGES - 1);

  seq_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [N_STAGES-1:0] rstn_q, rstn_d;
  logic                done_q, done_d;
  logic [N_STAGES-1:0] rdy_sync;
  logic [N_STAGES-1:0] stage_sel;
  logic                stage_rdy;
  logic                stage_go;

  sync_2ff #(.WIDTH(N_STAGES)) u_rdy_sync (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .d_i      (stage_ready_i),
    .q_o      (rdy_sync)
  );

  assign stage_sel = N_STAGES'(1) << idx_q;
  assign stage_rdy = |(rdy_sync & stage_sel);

`ifdef RESET_SEQ_TIMEOUT_EN
  logic tout_q, tout_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    rstn_d   = rstn_q;
    done_d   = done_q;
    stage_go = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
    tout_d   = tout_q;
`endif
    case (state_q)
      DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          rstn_d  = rstn_q | stage_sel;
          cnt_d   = '0;
          state_d = WAIT_RDY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_RDY: begin
        stage_go = stage_rdy;
`ifdef RESET_SEQ_TIMEOUT_EN
        // Ready on the expiry cycle wins, so the flag is only raised when ready is absent.
        if (!stage_rdy) begin
          if (cnt_q == TIMEOUT_LAST) begin
            tout_d   = 1'b1;
            stage_go = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        if (stage_go) begin
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            cnt_d   = '0;
            state_d = DELAY;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= DELAY;
      cnt_q   <= '0;
      idx_q   <= '0;
      rstn_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rstn_q  <= rstn_d;
      done_q  <= done_d;
    end
  end

`ifdef RESET_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) tout_q <= 1'b0;
    else           tout_q <= tout_d;
  end
  assign seq_timeout_o = tout_q;
`else
  assign seq_timeout_o = 1'b0;
`endif

  assign stage_rstn_o = rstn_q;
  assign stage_idx_o  = idx_q;
  assign seq_done_o   = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: per-stage release/accept times are derived arithmetically
// from the ready schedule, then every output is compared each cycle.
module tb_reset_sequencer;

  localparam int N     = 3;
  localparam int SD    = 4;
  localparam int TO    = 20;
  localparam int NEVER = 1 << 28;
`ifdef RESET_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetn;
  logic [N-1:0] ready;
  logic [N-1:0] rstn;
  logic [2:0]   idx;
  logic         done;
  logic         tout;

  int checks = 0;
  int errors = 0;

  // Model: edge numbers (counted from reset release) of each stage's release and acceptance.
  int rel[N];
  int acc[N];
  int ein[N];
  int to_edge;

  always #5 clk = ~clk;

  reset_sequencer #(
    .N_STAGES       (N),
    .STAGE_DELAY    (SD),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (17)
  ) dut (
    .clk_i         (clk),
    .resetn_i      (resetn),
    .stage_ready_i (ready),
    .stage_rstn_o  (rstn),
    .stage_idx_o   (idx),
    .seq_done_o    (done),
    .seq_timeout_o (tout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // off[k]: -1 = ready high from reset, NEVER = never raised, else raised off[k] clocks after release.
  // A raised input is seen by the sequencer three edges later; minimum dwell is one edge.
  function automatic void plan(input int off[N]);
    int start;
    int a;
    start   = SD;
    to_edge = NEVER;
    for (int k = 0; k < N; k++) begin
      if (off[k] < 0)           ein[k] = 0;
      else if (off[k] >= NEVER) ein[k] = NEVER;
      else                      ein[k] = start + off[k];
      a = (ein[k] + 3 > start + 1) ? ein[k] + 3 : start + 1;
      if (TO_EN && a > start + TO) begin
        a = start + TO;
        if (to_edge == NEVER) to_edge = a;
      end
      rel[k] = start;
      acc[k] = a;
      start  = a + SD;
    end
  endfunction

  task automatic run(input string name, input int off[N], input int abort_at);
    int ncyc;
    logic [N-1:0] exp_rstn;
    int exp_idx;
    plan(off);
    ncyc = (acc[N-1] >= NEVER) ? rel[N-1] + 1000 : acc[N-1] + 6;
    resetn = 1'b0;
    ready  = '0;
    for (int k = 0; k < N; k++) if (ein[k] == 0) ready[k] = 1'b1;
    repeat (2) @(negedge clk);
    check({name, ":rst_rstn"}, 32'(rstn), 0);
    check({name, ":rst_idx"},  32'(idx),  0);
    check({name, ":rst_done"}, 32'(done), 0);
    check({name, ":rst_tout"}, 32'(tout), 0);
    resetn = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk);
      @(negedge clk);
      exp_idx = 0;
      for (int k = 0; k < N; k++) begin
        exp_rstn[k] = (n >= rel[k]);
        if (k < N - 1 && n >= acc[k]) exp_idx++;
      end
      check({name, ":rstn"}, 32'(rstn), 32'(exp_rstn));
      check({name, ":idx"},  32'(idx),  32'(exp_idx));
      check({name, ":done"}, 32'(done), 32'(n >= acc[N-1]));
      check({name, ":tout"}, 32'(tout), 32'(n >= to_edge));
      if (n == abort_at) begin
        #2 resetn = 1'b0;
        #1;
        check({name, ":async_rstn"}, 32'(rstn), 0);
        check({name, ":async_idx"},  32'(idx),  0);
        check({name, ":async_done"}, 32'(done), 0);
        check({name, ":async_tout"}, 32'(tout), 0);
        return;
      end
      for (int k = 0; k < N; k++) begin
        if (ein[k] == n) ready[k] = 1'b1;
        else if (n == acc[k] + 2 && $urandom_range(0, 1) == 1) ready[k] = 1'b0;
      end
    end
  endtask

  initial begin
    int off[N];
    resetn = 1'b0;
    ready  = '0;

    run("late_ready", '{3, 3, 3}, 0);
    run("ready_held", '{-1, -1, -1}, 0);
    run("abort_wait1", '{3, 3, 3}, 16);
    run("restart", '{3, 3, 3}, 0);
    run("rdy_at_limit", '{17, 2, 0}, 0);
    if (TO_EN) run("timeout_s1", '{3, NEVER, 3}, 0);
    else       run("hang_s2", '{3, 3, NEVER}, 0);

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < N; k++) begin
        off[k] = int'($urandom_range(0, 26)) - 1;
        if (TO_EN && $urandom_range(0, 5) == 0) off[k] = NEVER;
      end
      run($sformatf("rand%0d", r), off, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
